// File: rtl/cosim_job_scheduler.sv
// Round-robin scheduler sharing one cosine-similarity engine between NREQ requesters.
// Optional COSIM_SCHED_STATS_EN adds saturating job/timeout counters.
module cosim_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int W       = 5,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*W*DW-1:0] req_vec_a,
  input  logic [NREQ*W*DW-1:0] req_vec_b,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 eng_start,
  output logic [W*DW-1:0]      eng_vec_a,
  output logic [W*DW-1:0]      eng_vec_b,
  input  logic                 eng_valid,
  input  logic [DW-1:0]        eng_similarity
`ifdef COSIM_SCHED_STATS_EN
  ,
  output logic [15:0]          stat_jobs,
  output logic [15:0]          stat_timeouts
`endif
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam int VW = W * DW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [PW-1:0] win_idx;
  logic          win_found;
  logic [VW-1:0] sel_a;
  logic [VW-1:0] sel_b;
  logic          timeout_hit;
  int            idx;

  // First requester with req set, searching upward from the one after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  always_comb begin
    sel_a = req_vec_a[win_idx*VW +: VW];
    sel_b = req_vec_b[win_idx*VW +: VW];
  end

  // cnt counts cycles since the start pulse, so the abort lands TIMEOUT cycles after ISSUE.
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      gnt       <= '0;
      ptr       <= PW'(NREQ - 1);
      cnt       <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      eng_vec_a <= '0;
      eng_vec_b <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            gnt          <= '0;
            gnt[win_idx] <= 1'b1;
            eng_vec_a    <= sel_a;
            eng_vec_b    <= sel_b;
            ptr          <= win_idx;
            cnt          <= '0;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= cnt + 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A valid result arriving on the last allowed cycle still wins over the abort.
          if (eng_valid) begin
            rsp_data <= eng_similarity;
            rsp_err  <= 1'b0;
            state    <= S_RESP;
          end else if (timeout_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state    <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          gnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == S_RESP) ? gnt : '0;
  assign busy      = (state != S_IDLE);
  assign eng_start = (state == S_ISSUE);

`ifdef COSIM_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_jobs     <= '0;
      stat_timeouts <= '0;
    end else if (state == S_RESP) begin
      if (stat_jobs != 16'hFFFF) stat_jobs <= stat_jobs + 16'd1;
      if (rsp_err && stat_timeouts != 16'hFFFF) stat_timeouts <= stat_timeouts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cosim_job_scheduler.sv
// Randomized bench for cosim_job_scheduler against a job-level reference model.
module tb_cosim_job_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 5;
  localparam int DW   = 32;
  localparam int T    = 8;
  localparam int VW   = W * DW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*VW-1:0]   req_vec_a, req_vec_b;
  logic [NREQ-1:0]      gnt, rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic                 rsp_err, busy, eng_start;
  logic [VW-1:0]        eng_vec_a, eng_vec_b;
  logic                 eng_valid;
  logic [DW-1:0]        eng_similarity;
`ifdef COSIM_SCHED_STATS_EN
  logic [15:0]          stat_jobs, stat_timeouts;
`endif

  cosim_job_scheduler #(.NREQ(NREQ), .W(W), .DW(DW), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_vec_a(req_vec_a), .req_vec_b(req_vec_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .eng_start(eng_start), .eng_vec_a(eng_vec_a), .eng_vec_b(eng_vec_b),
    .eng_valid(eng_valid), .eng_similarity(eng_similarity)
`ifdef COSIM_SCHED_STATS_EN
    , .stat_jobs(stat_jobs), .stat_timeouts(stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: last winner, last reported result, job statistics.
  int          ptr_m;
  logic [DW-1:0] data_m;
  logic        err_m;
  int          jobs_m, tos_m;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic rand_vecs();
    for (int k = 0; k < NREQ * W; k++) begin
      req_vec_a[k*DW +: DW] = $urandom;
      req_vec_b[k*DW +: DW] = $urandom;
    end
  endtask

  // One full job: d is the WAIT cycle (1 = first) in which the engine answers; d >= T means never.
  task automatic run_job(input logic [NREQ-1:0] pat, input int d, input logic [DW-1:0] sim,
                         input bit drop);
    int win, r;
    logic [NREQ-1:0] oh;
    logic [VW-1:0] ea, eb;
    req = pat;
    rand_vecs();
    eng_valid = 1'($urandom_range(0, 1));
    eng_similarity = $urandom;
    win = pick(pat, ptr_m);
    ptr_m = win;
    oh = '0;
    oh[win] = 1'b1;
    ea = req_vec_a[win*VW +: VW];
    eb = req_vec_b[win*VW +: VW];
    tick();
    chk("issue_gnt", gnt, oh);
    chk("issue_start", eng_start, 1'b1);
    chk("issue_busy", busy, 1'b1);
    chk("issue_vec_a", eng_vec_a, ea);
    chk("issue_vec_b", eng_vec_b, eb);
    chk("issue_rsp_valid", rsp_valid, '0);
    if (drop) req[win] = 1'b0;
    rand_vecs();
    eng_valid = 1'($urandom_range(0, 1));
    r = (d <= T - 1) ? d + 1 : T;
    for (int c = 1; c < r; c++) begin
      tick();
      chk("wait_busy", busy, 1'b1);
      chk("wait_start", eng_start, 1'b0);
      chk("wait_rsp_valid", rsp_valid, '0);
      chk("wait_gnt", gnt, oh);
      chk("wait_vec_a", eng_vec_a, ea);
      chk("wait_vec_b", eng_vec_b, eb);
      chk("wait_rsp_data", rsp_data, data_m);
      rand_vecs();
      eng_valid = (c == d);
      eng_similarity = (c == d) ? sim : DW'($urandom);
    end
    tick();
    eng_valid = 1'($urandom_range(0, 1));
    eng_similarity = $urandom;
    data_m = (d <= T - 1) ? sim : '0;
    err_m  = (d > T - 1);
    jobs_m++;
    if (err_m) tos_m++;
    chk("resp_valid", rsp_valid, oh);
    chk("resp_data", rsp_data, data_m);
    chk("resp_err", rsp_err, err_m);
    chk("resp_busy", busy, 1'b1);
    chk("resp_vec_a", eng_vec_a, ea);
    tick();
    chk("post_gnt", gnt, '0);
    chk("post_rsp_valid", rsp_valid, '0);
    chk("post_busy", busy, 1'b0);
    chk("post_rsp_data", rsp_data, data_m);
    req = '0;
    eng_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_gnt"}, gnt, '0);
    chk({tag, "_rsp_valid"}, rsp_valid, '0);
    chk({tag, "_rsp_data"}, rsp_data, '0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk({tag, "_start"}, eng_start, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_vec_a"}, eng_vec_a, '0);
    chk({tag, "_vec_b"}, eng_vec_b, '0);
`ifdef COSIM_SCHED_STATS_EN
    chk({tag, "_stat_jobs"}, stat_jobs, '0);
    chk({tag, "_stat_to"}, stat_timeouts, '0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_vec_a = '0;
    req_vec_b = '0;
    eng_valid = 1'b0;
    eng_similarity = '0;
    ptr_m = NREQ - 1;
    data_m = '0;
    err_m = 1'b0;
    jobs_m = 0;
    tos_m = 0;
    tick();
    tick();
    chk_reset_state("reset");
    rst = 1'b0;

    // All requesters held: grants rotate 0,1,2,3,0.
    for (int j = 0; j < 5; j++) run_job('1, 3, $urandom, 1'b0);
    // Single job from requester 2.
    run_job(4'b0100, 5, 32'h3F800000, 1'b0);
    // Engine never answers, then a normal job.
    run_job(4'b0010, 100, $urandom, 1'b0);
    run_job(4'b0010, 2, $urandom, 1'b0);
    // Valid lands on the last allowed cycle.
    run_job(4'b1000, T - 1, 32'hCAFE0001, 1'b0);

    // Spurious engine valid while idle.
    for (int k = 0; k < 3; k++) begin
      eng_valid = 1'b1;
      eng_similarity = $urandom;
      tick();
      chk("idle_busy", busy, 1'b0);
      chk("idle_gnt", gnt, '0);
      chk("idle_rsp_valid", rsp_valid, '0);
      chk("idle_rsp_data", rsp_data, data_m);
      chk("idle_rsp_err", rsp_err, err_m);
      chk("idle_start", eng_start, 1'b0);
    end
    eng_valid = 1'b0;

    for (int j = 0; j < 30; j++) begin
      run_job(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(1, T + 2), $urandom,
              1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        tick();
        chk("gap_busy", busy, 1'b0);
      end
    end

`ifdef COSIM_SCHED_STATS_EN
    chk("stat_jobs", stat_jobs, 16'(jobs_m));
    chk("stat_timeouts", stat_timeouts, 16'(tos_m));
`endif

    // Reset in the middle of WAIT drops the job.
    req = 4'b0010;
    rand_vecs();
    tick();
    chk("mid_issue_gnt", gnt, 4'b0010);
    tick();
    tick();
    chk("mid_wait_busy", busy, 1'b1);
    rst = 1'b1;
    req = '0;
    eng_valid = 1'b1;
    eng_similarity = $urandom;
    tick();
    rst = 1'b0;
    eng_valid = 1'b0;
    chk_reset_state("midrst");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst_no_rsp", rsp_valid, '0);
      chk("midrst_idle", busy, 1'b0);
    end
    ptr_m = NREQ - 1;
    data_m = '0;
    err_m = 1'b0;
    jobs_m = 0;
    tos_m = 0;
    run_job(4'b0001, 2, $urandom, 1'b0);
    run_job('1, 100, $urandom, 1'b0);
    run_job('1, 4, $urandom, 1'b1);
`ifdef COSIM_SCHED_STATS_EN
    chk("stat_jobs3", stat_jobs, 16'd3);
    chk("stat_timeouts1", stat_timeouts, 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
